bit_clock_ctrl: RTL and testbench

BIT_CLOCK_CTRL -- requirements
Module: bit_clock_ctrl

---
 rtl/bit_clock_ctrl_if.sv | 26 ++
 rtl/bit_clock_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bit_clock_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bit_clock_ctrl_if.sv
// Bundle of the edge-detector inputs, the operator controls and the
// recovered-clock outputs of the bit clock controller.
interface bit_clock_ctrl_if;
    logic        edge_valid;
    logic [15:0] edge_interval;
    logic        start;
    logic        type_toggle;
    logic [15:0] period;
    logic        period_valid;
    logic        datapath_clr;
    logic        locked;
    logic        type_sel;
    logic [2:0]  state;

    // Stimulus side: edge detector plus operator controls.
    modport master (
        output edge_valid, edge_interval, start, type_toggle,
        input  period, period_valid, datapath_clr, locked, type_sel, state
    );

    // Controller side.
    modport slave (
        input  edge_valid, edge_interval, start, type_toggle,
        output period, period_valid, datapath_clr, locked, type_sel, state
    );
endinterface

// File: rtl/bit_clock_ctrl.sv
// Bit clock recovery controller: acquires the shortest edge interval as the
// bit period, tracks it until enough consistent edges arrive, then holds lock
// while nudging the period by one clock per edge. Repeated short edges or a
// long silence declare loss and restart acquisition automatically.
module bit_clock_ctrl #(
    parameter logic [15:0] MIN_PERIOD = 16'd4,
    parameter int          ACQ_EDGES  = 16,
    parameter int          LOCK_EDGES = 8,
    parameter int          TOL        = 2,
    parameter int          MISS_MAX   = 3,
    parameter logic [15:0] TIMEOUT    = 16'd65535
) (
    input logic              clk_300M,
    input logic              rst_n,
    bit_clock_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_TRACK   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOST    = 3'd4
    } state_t;

    localparam logic [15:0] ACQ_N  = ACQ_EDGES[15:0];
    localparam logic [15:0] LOCK_N = LOCK_EDGES[15:0];
    localparam logic [15:0] MISS_N = MISS_MAX[15:0];
    localparam logic [16:0] TOL17  = TOL[16:0];

    state_t      state_q;
    logic [15:0] period_q;
    logic        period_valid_q;
    logic        locked_q;
    logic        datapath_clr_q;
    logic        type_sel_q;
    logic [15:0] min_reg;
    logic [15:0] acq_cnt;
    logic [15:0] good_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] idle_cnt;

    // Lower tolerance bound, clamped at zero.
    function automatic logic [16:0] lo_bound(input logic [15:0] p);
        logic [16:0] t;
        if ({1'b0, p} < TOL17) t = 17'd0;
        else                   t = {1'b0, p} - TOL17;
        return t;
    endfunction

    // Upper tolerance bound, clamped to the 16-bit range.
    function automatic logic [16:0] hi_bound(input logic [15:0] p);
        logic [16:0] t;
        t = {1'b0, p} + TOL17;
        if (t > 17'h0FFFF) t = 17'h0FFFF;
        return t;
    endfunction

    logic        accept;
    logic [16:0] ivl17;
    logic [16:0] lo;
    logic [16:0] hi;
    logic        short_edge;
    logic [15:0] min_next;
    logic [16:0] idle_inc;
    logic        timeout_hit;

    // Glitch-filtered edge, window tests and the silence detector.
    assign accept      = bus.edge_valid && (bus.edge_interval >= MIN_PERIOD);
    assign ivl17       = {1'b0, bus.edge_interval};
    assign lo          = lo_bound(period_q);
    assign hi          = hi_bound(period_q);
    assign short_edge  = accept && (ivl17 < lo);
    assign min_next    = (accept && (bus.edge_interval < min_reg)) ? bus.edge_interval : min_reg;
    assign idle_inc    = {1'b0, idle_cnt} + 17'd1;
    // An edge in the same cycle always resets the silence count instead.
    assign timeout_hit = !bus.edge_valid && (idle_inc >= {1'b0, TIMEOUT});

    // Main state machine with all of its registered outputs and counters.
    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            period_q       <= 16'hFFFF;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            datapath_clr_q <= 1'b0;
            min_reg        <= 16'hFFFF;
            acq_cnt        <= 16'd0;
            good_cnt       <= 16'd0;
            miss_cnt       <= 16'd0;
            idle_cnt       <= 16'd0;
        end else begin
            datapath_clr_q <= 1'b0;
            if (bus.start || (state_q == ST_LOST)) begin
                // Restart acquisition: an explicit start wins over any other
                // event, and LOST falls through here after its single cycle.
                state_q        <= ST_ACQUIRE;
                datapath_clr_q <= 1'b1;
                period_valid_q <= 1'b0;
                locked_q       <= 1'b0;
                min_reg        <= 16'hFFFF;
                acq_cnt        <= 16'd0;
                good_cnt       <= 16'd0;
                miss_cnt       <= 16'd0;
                idle_cnt       <= 16'd0;
            end else if (state_q != ST_IDLE) begin
                if (bus.edge_valid)           idle_cnt <= 16'd0;
                else if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;

                if (timeout_hit) begin
                    state_q        <= ST_LOST;
                    period_valid_q <= 1'b0;
                    locked_q       <= 1'b0;
                end else if (accept) begin
                    case (state_q)
                        ST_ACQUIRE: begin
                            acq_cnt <= acq_cnt + 16'd1;
                            min_reg <= min_next;
                            if ((acq_cnt + 16'd1) == ACQ_N) begin
                                state_q        <= ST_TRACK;
                                period_q       <= min_next;
                                period_valid_q <= 1'b1;
                                good_cnt       <= 16'd0;
                            end
                        end
                        ST_TRACK: begin
                            if (short_edge) begin
                                period_q <= bus.edge_interval;
                                good_cnt <= 16'd0;
                            end else begin
                                good_cnt <= good_cnt + 16'd1;
                                if ((good_cnt + 16'd1) == LOCK_N) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                    miss_cnt <= 16'd0;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if (short_edge) begin
                                miss_cnt <= miss_cnt + 16'd1;
                                if ((miss_cnt + 16'd1) == MISS_N) begin
                                    state_q        <= ST_LOST;
                                    period_valid_q <= 1'b0;
                                    locked_q       <= 1'b0;
                                end
                            end else begin
                                miss_cnt <= 16'd0;
                                // Long intervals are multi-bit runs and leave the period alone.
                                if ((ivl17 <= hi) && (bus.edge_interval != period_q)) begin
                                    if (bus.edge_interval > period_q) period_q <= period_q + 16'd1;
                                    else                              period_q <= period_q - 16'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output clock type flips on every key press, whatever the state.
    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n)               type_sel_q <= 1'b0;
        else if (bus.type_toggle) type_sel_q <= ~type_sel_q;
    end

    assign bus.state        = state_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.datapath_clr = datapath_clr_q;
    assign bus.type_sel     = type_sel_q;

endmodule

// File: tb/tb_bit_clock_ctrl.sv
// Testbench for bit_clock_ctrl: every driven cycle queues the outputs expected
// after the next clock edge; a monitor pops and compares them after that edge.
module tb_bit_clock_ctrl;

    typedef struct {
        string tag;
        int    st;
        int    per;
        int    pv;
        int    lk;
        int    clr;
        int    ts;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   exp_ts;
    exp_t sb_q[$];

    bit_clock_ctrl_if bus();

    bit_clock_ctrl #(.TIMEOUT(16'd100)) dut (
        .clk_300M (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must show after it.
    // Fields set to -1 are not compared.
    task automatic cyc(input logic ev, input logic [15:0] ivl, input logic st, input logic tt,
                       input string tag, input int es, input int ep, input int epv,
                       input int elk, input int eclr);
        exp_t e;
        bus.edge_valid    = ev;
        bus.edge_interval = ivl;
        bus.start         = st;
        bus.type_toggle   = tt;
        if (tt) exp_ts = 1 - exp_ts;
        e = '{tag, es, ep, epv, elk, eclr, exp_ts};
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.edge_valid  = 1'b0;
        bus.start       = 1'b0;
        bus.type_toggle = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, int'(bus.state), 0);
        chk({tag, ".period"}, int'(bus.period), 16'hFFFF);
        chk({tag, ".pv"}, int'(bus.period_valid), 0);
        chk({tag, ".locked"}, int'(bus.locked), 0);
        chk({tag, ".clr"}, int'(bus.datapath_clr), 0);
        chk({tag, ".type"}, int'(bus.type_sel), 0);
    endtask

    // Scoreboard consumer: compare after each edge that had stimulus queued.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.st  >= 0) chk({e.tag, ".state"},  int'(bus.state),        e.st);
            if (e.per >= 0) chk({e.tag, ".period"}, int'(bus.period),       e.per);
            if (e.pv  >= 0) chk({e.tag, ".pv"},     int'(bus.period_valid), e.pv);
            if (e.lk  >= 0) chk({e.tag, ".locked"}, int'(bus.locked),       e.lk);
            if (e.clr >= 0) chk({e.tag, ".clr"},    int'(bus.datapath_clr), e.clr);
            chk({e.tag, ".type"}, int'(bus.type_sel), e.ts);
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_ts = 0;
        rst_n = 1'b1;
        bus.edge_valid = 1'b0;
        bus.edge_interval = 16'd0;
        bus.start = 1'b0;
        bus.type_toggle = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores edges; key toggles anyway; start enters ACQUIRE.
        cyc(1'b1, 16'd40, 1'b0, 1'b0, "idle_edge", 0, 16'hFFFF, 0, 0, 0);
        cyc(1'b0, 16'd0,  1'b0, 1'b1, "idle_tgl",  0, 16'hFFFF, 0, 0, 0);
        cyc(1'b0, 16'd0,  1'b1, 1'b0, "start",     1, -1, 0, 0, 1);

        // Acquire 40/80 alternating with one glitch that must not count.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) cyc(1'b1, 16'd3, 1'b0, 1'b0, "glitch", 1, -1, 0, 0, 0);
            cyc(1'b1, (i % 2 == 1) ? 16'd80 : 16'd40, 1'b0, 1'b0,
                (i == 15) ? "acq_done" : "acq",
                (i == 15) ? 2 : 1, (i == 15) ? 40 : -1, (i == 15) ? 1 : 0, 0, 0);
        end

        // Eight consistent edges reach LOCKED.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 16'd40, 1'b0, 1'b0, "lock", (i == 7) ? 3 : 2, 40, 1, (i == 7) ? 1 : 0, 0);

        // In-window drift moves the period one step at a time; long runs do not.
        cyc(1'b1, 16'd41,  1'b0, 1'b0, "step_up",  3, 41, 1, 1, 0);
        cyc(1'b1, 16'd41,  1'b0, 1'b0, "hold41",   3, 41, 1, 1, 0);
        cyc(1'b1, 16'd120, 1'b0, 1'b0, "multibit", 3, 41, 1, 1, 0);
        cyc(1'b1, 16'd42,  1'b0, 1'b0, "step42",   3, 42, 1, 1, 0);
        cyc(1'b1, 16'd40,  1'b0, 1'b0, "step_dn",  3, 41, 1, 1, 0);
        cyc(1'b1, 16'd40,  1'b0, 1'b0, "to40",     3, 40, 1, 1, 0);
        cyc(1'b0, 16'd0,   1'b0, 1'b1, "lk_tgl",   3, 40, 1, 1, 0);

        // Short edges: a good edge resets the run, glitches are ignored, third consecutive loses lock.
        cyc(1'b1, 16'd30, 1'b0, 1'b0, "miss1",     3, 40, 1, 1, 0);
        cyc(1'b1, 16'd2,  1'b0, 1'b0, "glitch_lk", 3, 40, 1, 1, 0);
        cyc(1'b1, 16'd40, 1'b0, 1'b0, "miss_clr",  3, 40, 1, 1, 0);
        cyc(1'b1, 16'd30, 1'b0, 1'b0, "miss1b",    3, 40, 1, 1, 0);
        cyc(1'b1, 16'd30, 1'b0, 1'b0, "miss2",     3, 40, 1, 1, 0);
        cyc(1'b1, 16'd2,  1'b0, 1'b0, "glitch2",   3, 40, 1, 1, 0);
        cyc(1'b1, 16'd30, 1'b0, 1'b0, "lost",      4, 40, 0, 0, 0);
        cyc(1'b0, 16'd0,  1'b0, 1'b0, "reacq",     1, -1, 0, 0, 1);
        cyc(1'b0, 16'd0,  1'b0, 1'b0, "reacq2",    1, -1, 0, 0, 0);

        // Reacquire at 50, then a short edge in TRACK resets period and good count.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, (i == 7) ? 16'd50 : 16'd60, 1'b0, 1'b0, (i == 15) ? "acq2_done" : "acq2",
                (i == 15) ? 2 : 1, (i == 15) ? 50 : -1, (i == 15) ? 1 : 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'd50, 1'b0, 1'b0, "trk_good", 2, 50, 1, 0, 0);
        cyc(1'b1, 16'd20, 1'b0, 1'b0, "trk_short", 2, 20, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 16'd50, 1'b0, 1'b0, (i == 7) ? "relock" : "recount",
                (i == 7) ? 3 : 2, 20, 1, (i == 7) ? 1 : 0, 0);

        // Silence for the full timeout in LOCKED declares loss.
        for (int i = 0; i < 99; i++)
            cyc(1'b0, 16'd0, 1'b0, 1'b0, "quiet_lk", 3, 20, 1, 1, 0);
        cyc(1'b0, 16'd0, 1'b0, 1'b0, "timeout", 4, 20, 0, 0, 0);
        cyc(1'b0, 16'd0, 1'b0, 1'b0, "to_reacq", 1, -1, 0, 0, 1);

        // An edge landing on the timeout cycle suppresses it.
        for (int i = 0; i < 99; i++)
            cyc(1'b0, 16'd0, 1'b0, 1'b0, "quiet_acq", 1, -1, 0, 0, 0);
        cyc(1'b1, 16'd60, 1'b0, 1'b0, "edge_wins", 1, -1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 16'd0, 1'b0, 1'b0, "after_win", 1, -1, 0, 0, 0);

        // Restart from ACQUIRE together with a key press, relock at 40.
        cyc(1'b0, 16'd0, 1'b1, 1'b1, "restart", 1, -1, 0, 0, 1);
        for (int i = 0; i < 24; i++)
            cyc(1'b1, 16'd40, 1'b0, 1'b0, "relock40",
                (i < 15) ? 1 : ((i < 23) ? 2 : 3), (i < 15) ? -1 : 40,
                (i < 15) ? 0 : 1, (i == 23) ? 1 : 0, 0);

        // Asynchronous reset mid-cycle while LOCKED.
        #2 rst_n = 1'b0;
        exp_ts = 0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 16'd40, 1'b0, 1'b0, "post_rst",  0, 16'hFFFF, 0, 0, 0);
        cyc(1'b1, 16'd40, 1'b0, 1'b0, "post_rst2", 0, 16'hFFFF, 0, 0, 0);

        @(negedge clk);
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
